// File: rtl/sram_pkg.sv
// Shared types and size helpers for the single-port SRAM with init/clear sweep.
package sram_pkg;

    // INIT: power-up sweep, IDLE: accepting accesses, CLEAR: requested sweep
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Number of entries addressed by an address bus of the given width.
    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Bits covered by one write-enable lane; lane 0 sits at the LSBs.
    function automatic int lane_width(input int data_width, input int wmask_width);
        return data_width / wmask_width;
    endfunction

endpackage

// File: rtl/sram_sp_init_array_if.sv
// Access bus of the SRAM: chip select, write enable, lane mask, address,
// data in/out, clear request and ready.
interface sram_sp_init_array_if #(
    parameter int DATA_WIDTH  = 23,
    parameter int ADDR_WIDTH  = 5,
    parameter int WMASK_WIDTH = 1
) ();

    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic                   clr0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   ready0;

    modport master (
        output csb0, web0, wmask0, addr0, din0, clr0,
        input  dout0, ready0
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, clr0,
        output dout0, ready0
    );

endinterface

// File: rtl/sram_sp_core.sv
// Storage array: one write port with per-lane mask and a registered read.
// Only the read register is reset; array contents are left undefined.
module sram_sp_core
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 23,
    parameter int ADDR_WIDTH  = 5,
    parameter int WMASK_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic [WMASK_WIDTH-1:0] i_wmask,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0]  i_wdata,
    input  logic                   i_re,
    output logic [DATA_WIDTH-1:0]  o_rdata
);

    localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH);
    localparam int LANE_W    = lane_width(DATA_WIDTH, WMASK_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Masked write: each enabled lane of the addressed word takes its slice of the write data
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (i_wmask[i]) begin
                    r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read register: loads only on a read, otherwise holds its last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sp_init_array.sv
// Single-port SRAM wrapper that sweeps INIT_VALUE into every entry after
// reset and on a clear request, and gates host accesses while sweeping.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | post-reset sweep, one entry per cycle, accesses ignored
// IDLE  | ready0=1, host reads/writes accepted, clr0 starts a sweep
// CLEAR | requested sweep, same as INIT, further clr0 ignored
module sram_sp_init_array
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 23,
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    WMASK_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input logic                 clk0,
    input logic                 rst0_n,
    sram_sp_init_array_if.slave bus
);

    localparam int                    RAM_DEPTH = ram_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_cnt;

    logic                   w_ready;
    logic                   w_sweep;
    logic                   w_accept;
    logic                   w_we;
    logic                   w_re;
    logic [WMASK_WIDTH-1:0] w_wmask;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [DATA_WIDTH-1:0]  w_rdata;

    // State register
    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: sweeps end after the last entry; clr0 only matters in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT, CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (bus.clr0) begin
                    w_state_nxt = CLEAR;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // State outputs: ready while idle, sweeping in INIT and CLEAR
    always_comb begin
        w_ready = 1'b0;
        w_sweep = 1'b0;
        case (r_state)
            IDLE:        w_ready = 1'b1;
            INIT, CLEAR: w_sweep = 1'b1;
            default:     ;
        endcase
    end

    // Sweep counter: advances once per sweep cycle and rolls back to 0 after the last entry
    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            r_cnt <= '0;
        end else if (w_sweep) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_accept = w_ready & ~bus.csb0;

    // Port/sweep mux: the sweep owns the write port; nothing reaches the array during reset
    always_comb begin
        w_wmask = bus.wmask0;
        w_addr  = bus.addr0;
        w_wdata = bus.din0;
        w_we    = w_accept & ~bus.web0;
        w_re    = w_accept & bus.web0;
        if (w_sweep) begin
            w_wmask = '1;
            w_addr  = r_cnt;
            w_wdata = INIT_VALUE;
            w_we    = 1'b1;
            w_re    = 1'b0;
        end
        if (!rst0_n) begin
            w_we = 1'b0;
            w_re = 1'b0;
        end
    end

    sram_sp_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WMASK_WIDTH (WMASK_WIDTH)
    ) u_core (
        .clk     (clk0),
        .rst_n   (rst0_n),
        .i_we    (w_we),
        .i_wmask (w_wmask),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

    assign bus.dout0  = w_rdata;
    assign bus.ready0 = w_ready;

endmodule

// File: tb/tb_sram_sp_init_array.sv
// Bench for sram_sp_init_array: a 23-bit single-lane instance and a
// 32-bit four-lane instance, table-driven accesses with a read scoreboard
// and hand-written sweep / reset sequences.
module tb_sram_sp_init_array;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic rst_a_n;
    logic rst_b_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_a;
    logic [31:0] last_b;

    typedef struct {
        bit          web;
        logic [4:0]  addr;
        logic [22:0] din;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];

    sram_sp_init_array_if #(.DATA_WIDTH(23), .ADDR_WIDTH(5), .WMASK_WIDTH(1)) ifa ();
    sram_sp_init_array_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WMASK_WIDTH(4)) ifb ();

    sram_sp_init_array #(
        .DATA_WIDTH (23), .ADDR_WIDTH (5), .WMASK_WIDTH (1), .INIT_VALUE (23'h0)
    ) u_dut_a (
        .clk0   (clk0),
        .rst0_n (rst_a_n),
        .bus    (ifa)
    );

    sram_sp_init_array #(
        .DATA_WIDTH (32), .ADDR_WIDTH (5), .WMASK_WIDTH (4), .INIT_VALUE (32'h0)
    ) u_dut_b (
        .clk0   (clk0),
        .rst0_n (rst_b_n),
        .bus    (ifb)
    );

    task automatic tick();
        @(posedge clk0);
        @(negedge clk0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pop_exp(input string name, output logic [31:0] e);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=empty_queue required=entry", name);
            e = 32'hx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // One access on DUT A; a read pushes its expectation, a write must leave dout0 alone
    task automatic op_a(input bit web, input logic [4:0] addr, input logic [22:0] din,
                        input bit clr, input logic [22:0] exp, input string name);
        logic [31:0] e;
        ifa.csb0   = 1'b0;
        ifa.web0   = web;
        ifa.addr0  = addr;
        ifa.din0   = din;
        ifa.wmask0 = 1'b1;
        ifa.clr0   = clr;
        if (web) exp_q.push_back({9'd0, exp});
        tick();
        ifa.csb0 = 1'b1;
        ifa.web0 = 1'b1;
        ifa.clr0 = 1'b0;
        if (web) begin
            pop_exp(name, e);
            chk(name, {9'd0, ifa.dout0}, e);
            last_a = e;
        end else begin
            chk({name, "_hold"}, {9'd0, ifa.dout0}, last_a);
        end
    endtask

    task automatic op_b(input bit web, input logic [4:0] addr, input logic [31:0] din,
                        input logic [3:0] mask, input logic [31:0] exp, input string name);
        logic [31:0] e;
        ifb.csb0   = 1'b0;
        ifb.web0   = web;
        ifb.addr0  = addr;
        ifb.din0   = din;
        ifb.wmask0 = mask;
        ifb.clr0   = 1'b0;
        if (web) exp_q.push_back(exp);
        tick();
        ifb.csb0 = 1'b1;
        ifb.web0 = 1'b1;
        if (web) begin
            pop_exp(name, e);
            chk(name, ifb.dout0, e);
            last_b = e;
        end else begin
            chk({name, "_hold"}, ifb.dout0, last_b);
        end
    endtask

    // 32-cycle sweep on DUT A: ready low until the 32nd edge, dout0 frozen; optional
    // read + clr0 injected at cycle inject_at must be ignored
    task automatic sweep_a(input string name, input int inject_at);
        chk({name, "_rdy_start"}, {31'd0, ifa.ready0}, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            if (k == inject_at) begin
                ifa.csb0  = 1'b0;
                ifa.web0  = 1'b1;
                ifa.addr0 = 5'd7;
                ifa.clr0  = 1'b1;
            end
            tick();
            ifa.csb0 = 1'b1;
            ifa.clr0 = 1'b0;
            chk({name, "_rdy"}, {31'd0, ifa.ready0}, (k == 32) ? 32'd1 : 32'd0);
            chk({name, "_dout"}, {9'd0, ifa.dout0}, last_a);
        end
    endtask

    initial begin
        ifa.csb0 = 1'b1; ifa.web0 = 1'b1; ifa.wmask0 = 1'b1; ifa.addr0 = '0; ifa.din0 = '0; ifa.clr0 = 1'b0;
        ifb.csb0 = 1'b1; ifb.web0 = 1'b1; ifb.wmask0 = 4'hF; ifb.addr0 = '0; ifb.din0 = '0; ifb.clr0 = 1'b0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        last_a  = 32'd0;
        last_b  = 32'd0;

        // table: full read-back of the swept array, then writes and read-backs
        for (int a = 0; a < 32; a++) tbl.push_back('{1'b1, 5'(a), 23'h0, 23'h0});
        tbl.push_back('{1'b0, 5'd7,  23'h5A5A5,  23'h0});
        tbl.push_back('{1'b1, 5'd7,  23'h0,      23'h5A5A5});
        tbl.push_back('{1'b0, 5'd0,  23'h7FFFFF, 23'h0});
        tbl.push_back('{1'b0, 5'd31, 23'h123456, 23'h0});
        tbl.push_back('{1'b1, 5'd31, 23'h0,      23'h123456});
        tbl.push_back('{1'b1, 5'd0,  23'h0,      23'h7FFFFF});
        tbl.push_back('{1'b1, 5'd7,  23'h0,      23'h5A5A5});

        tick(); tick(); tick();
        chk("rst_ready_a", {31'd0, ifa.ready0}, 32'd0);
        chk("rst_dout_a", {9'd0, ifa.dout0}, 32'd0);
        chk("rst_ready_b", {31'd0, ifb.ready0}, 32'd0);

        // release both resets before the same edge; DUT A's init sweep is timed
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        sweep_a("init", 0);

        for (int i = 0; i < tbl.size(); i++) begin
            op_a(tbl[i].web, tbl[i].addr, tbl[i].din, 1'b0, tbl[i].exp, $sformatf("tbl%0d", i));
            chk("tbl_ready", {31'd0, ifa.ready0}, 32'd1);
        end

        // clear together with a write to 31; read attempted mid-sweep is ignored
        op_a(1'b0, 5'd31, 23'h1, 1'b1, 23'h0, "clr_wr");
        sweep_a("clr", 5);
        op_a(1'b1, 5'd31, 23'h0, 1'b0, 23'h0, "clr_rd31");
        op_a(1'b1, 5'd7,  23'h0, 1'b0, 23'h0, "clr_rd7");

        // clear together with a read: read data latched first, then the sweep
        op_a(1'b0, 5'd5, 23'h2AAAAA, 1'b0, 23'h0, "crd_wr");
        op_a(1'b1, 5'd5, 23'h0, 1'b1, 23'h2AAAAA, "crd_rd");
        sweep_a("crd", 0);
        op_a(1'b1, 5'd5, 23'h0, 1'b0, 23'h0, "crd_rd5");

        // reset mid-sweep at entry 10, held 2 cycles, then a full sweep
        op_a(1'b0, 5'd9, 23'h0F0F0F, 1'b0, 23'h0, "mr_wr");
        op_a(1'b1, 5'd9, 23'h0, 1'b0, 23'h0F0F0F, "mr_rd");
        rst_a_n = 1'b0;
        tick();
        last_a = 32'd0;
        chk("mr_rst_dout", {9'd0, ifa.dout0}, 32'd0);
        chk("mr_rst_ready", {31'd0, ifa.ready0}, 32'd0);
        rst_a_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("mr_pre_rdy", {31'd0, ifa.ready0}, 32'd0);
        end
        rst_a_n = 1'b0;
        tick(); tick();
        chk("mr_hold_rdy", {31'd0, ifa.ready0}, 32'd0);
        chk("mr_hold_dout", {9'd0, ifa.dout0}, 32'd0);
        rst_a_n = 1'b1;
        sweep_a("mr", 0);
        op_a(1'b1, 5'd9, 23'h0, 1'b0, 23'h0, "mr_rd9");

        // four-lane instance: masked writes
        chk("b_ready", {31'd0, ifb.ready0}, 32'd1);
        op_b(1'b0, 5'd3, 32'hFFFFFFFF, 4'hF, 32'h0, "b_wr_all");
        op_b(1'b0, 5'd3, 32'h12345678, 4'b0101, 32'h0, "b_wr_0101");
        op_b(1'b1, 5'd3, 32'h0, 4'h0, 32'hFF34FF78, "b_rd_0101");
        op_b(1'b0, 5'd3, 32'hAABBCCDD, 4'b1010, 32'h0, "b_wr_1010");
        op_b(1'b1, 5'd3, 32'h0, 4'h0, 32'hAA34CC78, "b_rd_1010");
        op_b(1'b0, 5'd3, 32'h00000000, 4'b0000, 32'h0, "b_wr_none");
        op_b(1'b1, 5'd3, 32'h0, 4'h0, 32'hAA34CC78, "b_rd_none");
        op_b(1'b1, 5'd4, 32'h0, 4'h0, 32'h00000000, "b_rd4");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_sp_init_array.md
SRAM_SP_INIT_ARRAY -- requirements
Module: sram_sp_init_array

Interface
REQ-001 DATA_WIDTH, 23, word width in bits.
REQ-002 ADDR_WIDTH, 5, address width; RAM_DEPTH = 2**ADDR_WIDTH entries.
REQ-003 WMASK_WIDTH, 1, number of write-enable lanes; DATA_WIDTH SHALL be a multiple of WMASK_WIDTH, and each lane covers DATA_WIDTH/WMASK_WIDTH contiguous bits, with lane 0 at the LSBs.
REQ-004 INIT_VALUE, 0, DATA_WIDTH-wide value written to every entry by a clear sweep.
REQ-005 clk0  in  1  single clock; all state changes on its rising edge.
REQ-006 rst0_n  in  1  synchronous, active-low reset.
REQ-007 csb0  in  1  active-low chip select.
REQ-008 web0  in  1  active-low write enable, qualified by csb0=0.
REQ-009 wmask0  in  WMASK_WIDTH  per-lane write enable, active high.
REQ-010 addr0  in  ADDR_WIDTH  access address.
REQ-011 din0  in  DATA_WIDTH  write data.
REQ-012 clr0  in  1  one-cycle request to clear all entries to INIT_VALUE.
REQ-013 dout0  out  DATA_WIDTH  registered read data.
REQ-014 ready0  out  1  high when accesses are accepted (IDLE state).

Function
REQ-015 The block SHALL have three states: INIT (entered on reset), IDLE, and CLEAR.
REQ-016 An access is accepted only when ready0=1 and csb0=0; the block SHALL ignore csb0/web0/addr0/din0/wmask0 when ready0=0.
REQ-017 An accepted write (web0=0) SHALL update only the lanes of mem[addr0] whose wmask0 bit is 1, at the accepting edge.
REQ-018 An accepted write SHALL leave dout0 unchanged.
REQ-019 An accepted read (web0=1) SHALL present mem[addr0] on dout0 after the accepting edge, giving 1-cycle latency.
REQ-020 A read SHALL return data written by any earlier accepted write.
REQ-021 dout0 SHALL hold its last value in every cycle without an accepted read, including during INIT and CLEAR.
REQ-022 In INIT and CLEAR, a sweep counter starting at 0 SHALL write INIT_VALUE (all lanes) to mem[counter] once per cycle.
REQ-023 The sweep counter SHALL increment by 1 per cycle.
REQ-024 After writing entry RAM_DEPTH-1, the state SHALL go to IDLE, and the counter SHALL wrap to 0.
REQ-025 A sweep SHALL take exactly RAM_DEPTH cycles.
REQ-026 ready0 SHALL rise in the cycle after the last sweep write.
REQ-027 clr0=1 while in IDLE SHALL move the state to CLEAR at that edge, and ready0 SHALL fall in the next cycle.
REQ-028 clr0=1 together with an accepted access in the same cycle: the access SHALL complete first (write committed, or read data latched), then the sweep starts.
REQ-029 clr0 asserted in INIT or CLEAR SHALL be ignored; there is no sweep restart and no queuing.
REQ-030 No storage contents other than those produced by the sweep are guaranteed after reset.

Reset
REQ-031 rst0_n=0 at a rising edge SHALL set the state to INIT, the sweep counter to 0, dout0 to 0 and ready0 to 0.
REQ-032 Reset asserted mid-sweep or mid-access SHALL abandon that operation, and a full sweep SHALL restart from entry 0 after release.
REQ-033 ready0 SHALL first be 1 exactly RAM_DEPTH cycles after the first edge with rst0_n=1.

Structure
REQ-034 The state enum (INIT, IDLE, CLEAR) SHALL live in the shared package sram_pkg.
REQ-035 The RAM_DEPTH and lane-width derivation functions SHALL also live in sram_pkg.
REQ-036 Storage SHALL be a separate sub-module, sram_sp_core: a single write port with lane mask and a registered read.
REQ-037 The top level SHALL contain the FSM, the sweep counter, and the port/sweep mux.

Verification
REQ-038 Reset, then with defaults: release rst0_n -> ready0=0 for 32 cycles, then 1; afterwards read of addr 0..31 -> dout0=0 each, one cycle after each request.
REQ-039 Write 23'h5A5A5 to addr 7, then read addr 7 -> dout0=23'h5A5A5 on the cycle after the read; dout0 unchanged during the write cycle.
REQ-040 DATA_WIDTH=32, WMASK_WIDTH=4: write 32'hFFFFFFFF to addr 3, then write 32'h12345678 with wmask0=4'b0101 -> read addr 3 gives 32'hFF34FF78.
REQ-041 In IDLE, assert clr0 together with a write of 23'h1 to addr 31 -> ready0 low for 32 cycles; a later read of addr 31 gives INIT_VALUE; a read attempted during the sweep leaves dout0 unchanged.
REQ-042 Pull rst0_n low at sweep entry 10, hold 2 cycles, then release -> ready0 stays 0 for 32 cycles after release and dout0=0 throughout.
